// File: rtl/grey_display.sv
// Purpose: synchronise three async Gray-code decade digits, decode to BCD, scan them onto a 7-seg bus.
// Latency: input stable before edge N reaches o_bcd at edge N+3 and o_seg one edge later.
// Backpressure: none; free-running display with no handshake.
module grey_display #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    output logic [3:0] o_bcd_100,
    output logic [3:0] o_bcd_010,
    output logic [3:0] o_bcd_001,
    output logic [6:0] o_seg,
    output logic [2:0] o_an,
    output logic       o_err
);
    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    // Digit order in all packed arrays: [0] ones, [1] tens, [2] hundreds.
    logic [2:0][4:0] din;
    logic [2:0][4:0] s1, s2, s3;
    logic [2:0][3:0] bcd;
    logic [2:0][4:0] dec;
    logic [2:0]      stable;
    logic            any_bad;

    logic [15:0] cnt;
    logic [1:0]  idx, idx_nxt;
    logic        cnt_wrap;
    logic [3:0]  sel_bcd;
    logic        blank;
    logic [6:0]  seg_nxt;

    assign din       = {i_100, i_010, i_001};
    assign o_bcd_001 = bcd[0];
    assign o_bcd_010 = bcd[1];
    assign o_bcd_100 = bcd[2];

    // Returns {valid, bcd}; only the ten Johnson-style codes are legal.
    function automatic logic [4:0] decode(input logic [4:0] code);
        case (code)
            5'b00000: decode = {1'b1, 4'd0};
            5'b00001: decode = {1'b1, 4'd1};
            5'b00011: decode = {1'b1, 4'd2};
            5'b00111: decode = {1'b1, 4'd3};
            5'b01111: decode = {1'b1, 4'd4};
            5'b11111: decode = {1'b1, 4'd5};
            5'b11110: decode = {1'b1, 4'd6};
            5'b11100: decode = {1'b1, 4'd7};
            5'b11000: decode = {1'b1, 4'd8};
            5'b10000: decode = {1'b1, 4'd9};
            default:  decode = 5'b0;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    always_comb begin
        dec     = '0;
        stable  = '0;
        any_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dec[i]    = decode(s2[i]);
            stable[i] = (s2[i] == s3[i]);
            if (stable[i] && !dec[i][4])
                any_bad = 1'b1;
        end
    end

    // Segment data is chosen for the digit that o_an selects on the same edge.
    always_comb begin
        cnt_wrap = (cnt == CNT_LAST);
        idx_nxt  = idx;
        if (cnt_wrap)
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        sel_bcd = bcd[0];
        blank   = 1'b0;
        case (idx_nxt)
            2'd1: begin
                sel_bcd = bcd[1];
                blank   = BLANK_LZ && (bcd[2] == 4'd0) && (bcd[1] == 4'd0);
            end
            2'd2: begin
                sel_bcd = bcd[2];
                blank   = BLANK_LZ && (bcd[2] == 4'd0);
            end
            default: begin
                sel_bcd = bcd[0];
                blank   = 1'b0;
            end
        endcase
        seg_nxt = blank ? 7'h00 : seg_of(sel_bcd);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            bcd   <= '0;
            o_err <= 1'b0;
            cnt   <= '0;
            idx   <= 2'd0;
            o_an  <= 3'b001;
            o_seg <= 7'h3F;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < 3; i++) begin
                if (stable[i] && dec[i][4])
                    bcd[i] <= dec[i][3:0];
            end
            if (any_bad)
                o_err <= 1'b1;
            cnt   <= cnt_wrap ? 16'd0 : cnt + 16'd1;
            idx   <= idx_nxt;
            o_an  <= 3'b001 << idx_nxt;
            o_seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_grey_display.sv
// Bench for grey_display: constant vectors, corner sequences and a randomized run checked against a reference model.
module tb_grey_display;
    localparam int SD = 4;
    localparam logic [4:0] CODE [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                         5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] in_100, in_010, in_001;
    logic [3:0] b_bcd_100, b_bcd_010, b_bcd_001, n_bcd_100, n_bcd_010, n_bcd_001;
    logic [6:0] b_seg, n_seg;
    logic [2:0] b_an, n_an;
    logic       b_err, n_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    grey_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_100(in_100), .i_010(in_010), .i_001(in_001),
        .o_bcd_100(b_bcd_100), .o_bcd_010(b_bcd_010), .o_bcd_001(b_bcd_001),
        .o_seg(b_seg), .o_an(b_an), .o_err(b_err)
    );

    grey_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_100(in_100), .i_010(in_010), .i_001(in_001),
        .o_bcd_100(n_bcd_100), .o_bcd_010(n_bcd_010), .o_bcd_001(n_bcd_001),
        .o_seg(n_seg), .o_an(n_an), .o_err(n_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic int decode_ref(input logic [4:0] c);
        for (int i = 0; i < 10; i++)
            if (CODE[i] == c) return i;
        return -1;
    endfunction

    // idx: 0 ones, 1 tens, 2 hundreds
    function automatic logic [6:0] exp_seg(input int idx, input int h, input int t, input int o, input bit blank);
        if (idx == 2) return (blank && h == 0) ? 7'h00 : SEG[h];
        if (idx == 1) return (blank && h == 0 && t == 0) ? 7'h00 : SEG[t];
        return SEG[o];
    endfunction

    // Reference model: a digit's value is taken when the samples from two and three
    // edges ago agree; the scan position is simply elapsed cycles since reset.
    logic [4:0] hist [3][3];
    int         mb [3];
    bit         m_err;
    int         n_sc;
    logic [6:0] m_seg_b, m_seg_n;
    logic [2:0] m_an;

    always @(posedge clk) begin : model
        logic [4:0] cur [3];
        int idx;
        int v;
        cur[0] = in_001;
        cur[1] = in_010;
        cur[2] = in_100;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                mb[d] = 0;
                for (int k = 0; k < 3; k++) hist[d][k] = 5'b0;
            end
            m_err = 1'b0;
            n_sc = 0;
            m_an = 3'b001;
            m_seg_b = 7'h3F;
            m_seg_n = 7'h3F;
        end else begin
            n_sc++;
            idx = (n_sc / SD) % 3;
            m_seg_b = exp_seg(idx, mb[2], mb[1], mb[0], 1'b1);
            m_seg_n = exp_seg(idx, mb[2], mb[1], mb[0], 1'b0);
            m_an = 3'(1 << idx);
            for (int d = 0; d < 3; d++) begin
                if (hist[d][1] == hist[d][2]) begin
                    v = decode_ref(hist[d][1]);
                    if (v < 0) m_err = 1'b1;
                    else mb[d] = v;
                end
                hist[d][2] = hist[d][1];
                hist[d][1] = hist[d][0];
                hist[d][0] = cur[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_bcd_100", b_bcd_100, mb[2]);
            check("m_bcd_010", b_bcd_010, mb[1]);
            check("m_bcd_001", b_bcd_001, mb[0]);
            check("m_an", b_an, m_an);
            check("m_seg", b_seg, m_seg_b);
            check("m_err", b_err, m_err);
            check("m_an_nolz", n_an, m_an);
            check("m_seg_nolz", n_seg, m_seg_n);
        end
    end

    typedef struct packed {
        logic [4:0]      c100, c010, c001;
        logic [3:0]      b100, b010, b001;
        logic [2:0][6:0] sb;
        logic [2:0][6:0] sn;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] c100, input logic [4:0] c010, input logic [4:0] c001,
                                input logic [3:0] b100, input logic [3:0] b010, input logic [3:0] b001,
                                input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh,
                                input logic [6:0] no, input logic [6:0] nt, input logic [6:0] nh);
        vec_t r;
        r.c100 = c100; r.c010 = c010; r.c001 = c001;
        r.b100 = b100; r.b010 = b010; r.b001 = b001;
        r.sb = {sh, st, so};
        r.sn = {nh, nt, no};
        return r;
    endfunction

    function automatic int an_idx(input logic [2:0] an);
        case (an)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 0;
        endcase
    endfunction

    vec_t tab [6];

    initial begin
        logic [4:0] hold [3];
        logic [2:0] seen_b, seen_n;
        int ib, inn, r;

        tab[0] = mk(5'b00000, 5'b00011, 5'b11000, 4'd0, 4'd2, 4'd8, 7'h7F, 7'h5B, 7'h00, 7'h7F, 7'h5B, 7'h3F);
        tab[1] = mk(5'b00000, 5'b00000, 5'b00000, 4'd0, 4'd0, 4'd0, 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F);
        tab[2] = mk(5'b00001, 5'b00000, 5'b11111, 4'd1, 4'd0, 4'd5, 7'h6D, 7'h3F, 7'h06, 7'h6D, 7'h3F, 7'h06);
        tab[3] = mk(5'b10000, 5'b01111, 5'b00000, 4'd9, 4'd4, 4'd0, 7'h3F, 7'h66, 7'h6F, 7'h3F, 7'h66, 7'h6F);
        tab[4] = mk(5'b00000, 5'b00000, 5'b11100, 4'd0, 4'd0, 4'd7, 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);
        tab[5] = mk(5'b00000, 5'b11110, 5'b00111, 4'd0, 4'd6, 4'd3, 7'h4F, 7'h7D, 7'h00, 7'h4F, 7'h7D, 7'h3F);

        rst = 1'b1;
        in_100 = 5'b0; in_010 = 5'b0; in_001 = 5'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst_an", b_an, 3'b001);
        check("rst_seg", b_seg, 7'h3F);
        check("rst_bcd", {b_bcd_100, b_bcd_010, b_bcd_001}, 12'h000);
        check("rst_err", b_err, 1'b0);
        rst = 1'b0;
        tick(3);

        // Latency: 028 must appear on the fourth edge after driving, not before.
        in_100 = 5'b00000; in_010 = 5'b00011; in_001 = 5'b11000;
        tick(1); check("lat_e1", {b_bcd_010, b_bcd_001}, 8'h00);
        tick(1); check("lat_e2", {b_bcd_010, b_bcd_001}, 8'h00);
        tick(1); check("lat_e3", {b_bcd_010, b_bcd_001}, 8'h00);
        tick(1); check("lat_e4", {b_bcd_100, b_bcd_010, b_bcd_001}, 12'h028);

        for (int i = 0; i < 6; i++) begin
            in_100 = tab[i].c100; in_010 = tab[i].c010; in_001 = tab[i].c001;
            tick(6);
            check("vec_bcd", {b_bcd_100, b_bcd_010, b_bcd_001}, {tab[i].b100, tab[i].b010, tab[i].b001});
            check("vec_bcd_nolz", {n_bcd_100, n_bcd_010, n_bcd_001}, {tab[i].b100, tab[i].b010, tab[i].b001});
            seen_b = 3'b0; seen_n = 3'b0;
            for (int c = 0; c < 3 * SD; c++) begin
                tick(1);
                ib = an_idx(b_an);
                inn = an_idx(n_an);
                check("vec_seg", b_seg, tab[i].sb[ib]);
                check("vec_seg_nolz", n_seg, tab[i].sn[inn]);
                seen_b |= b_an;
                seen_n |= n_an;
            end
            check("vec_scan_all", {seen_b, seen_n}, 6'b111111);
        end

        // Held invalid code sets the sticky error and leaves BCD untouched.
        in_001 = 5'b00111;
        tick(5);
        check("inv_pre_err", b_err, 1'b0);
        in_001 = 5'b00101;
        tick(4);
        check("inv_err", b_err, 1'b1);
        check("inv_hold", b_bcd_001, 4'd3);
        in_001 = 5'b00111;
        tick(5);
        check("inv_sticky", b_err, 1'b1);
        rst = 1'b1;
        tick(1);
        check("inv_rst_clr", b_err, 1'b0);
        rst = 1'b0;

        // Single-cycle glitch between two valid codes is ignored.
        in_001 = 5'b00011;
        tick(6);
        check("gl_pre", b_bcd_001, 4'd2);
        in_001 = 5'b01010;
        tick(1);
        in_001 = 5'b00111;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check("gl_no_show", (b_bcd_001 == 4'd2) || (b_bcd_001 == 4'd3), 1'b1);
            check("gl_err", b_err, 1'b0);
        end
        check("gl_final", b_bcd_001, 4'd3);

        // Gray-order sweep with a 9->0 wrap and a reset in the middle.
        for (int s = 0; s <= 10; s++) begin
            in_100 = CODE[s % 10]; in_010 = CODE[s % 10]; in_001 = CODE[s % 10];
            tick(4);
            check("sw_bcd", {b_bcd_100, b_bcd_010, b_bcd_001}, {3{4'(s % 10)}});
            if (s == 5) begin
                tick(2);
                rst = 1'b1;
                tick(1);
                check("sw_rst_an", b_an, 3'b001);
                check("sw_rst_seg", b_seg, 7'h3F);
                check("sw_rst_bcd", {b_bcd_100, b_bcd_010, b_bcd_001}, 12'h000);
                rst = 1'b0;
                tick(3);
                check("sw_reacq_early", b_bcd_001, 4'd0);
                tick(1);
                check("sw_reacq", {b_bcd_100, b_bcd_010, b_bcd_001}, 12'h555);
            end
        end

        // Randomized run: valid code changes, one-cycle glitches, rare held invalids and resets.
        hold[0] = in_001; hold[1] = in_010; hold[2] = in_100;
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] drv [3];
            for (int d = 0; d < 3; d++) begin
                r = $urandom_range(0, 999);
                if (r < 120) hold[d] = CODE[$urandom_range(0, 9)];
                else if (r < 124) hold[d] = 5'($urandom);
                drv[d] = hold[d];
                if (r >= 124 && r < 160) drv[d] = 5'($urandom);
            end
            in_001 = drv[0]; in_010 = drv[1]; in_100 = drv[2];
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
